i2c_bus_frontend: RTL

//  Multi-bus I2C physical front end between the raw open-drain pads and I2C controller cores.
//  Per bus:
//  - synchronises and glitch-filters SDA/SCL
//  - detects START/STOP, tracks bus busy, flags arbitration loss and SCL-low timeout
//  - registers the open-drain drive values
//  - exposes per-bus sticky status and one maskable interrupt

---
 rtl/i2c_bus_frontend_pkg.sv | 28 ++
 rtl/i2c_bus_frontend_line_filter.sv | 62 ++++++
 rtl/i2c_bus_frontend.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/i2c_bus_frontend_pkg.sv
// ============================================================================
// Module      : i2c_pkg
// Description : Shared event indices and the packed status type for the
//               I2C bus front end.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package i2c_pkg;

    // Bit positions of the per-bus events inside a status nibble
    localparam int EV_START = 0;
    localparam int EV_STOP  = 1;
    localparam int EV_ARB   = 2;
    localparam int EV_TO    = 3;
    localparam int EV_W     = 4;

    // Sticky per-bus status, MSB first: {timeout, arb_lost, stop, start}
    typedef struct packed {
        logic timeout;
        logic arb_lost;
        logic stop;
        logic start;
    } i2c_status_t;

endpackage

`default_nettype wire

// File: rtl/i2c_bus_frontend_line_filter.sv
// ============================================================================
// Module      : i2c_line_filter
// Description : Two-flop synchroniser followed by a stability filter. The
//               filtered output follows the synchronised line only after it
//               has held one value for FILTER_LEN consecutive cycles.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module i2c_line_filter #(
    parameter int FILTER_LEN = 4
) (
    input  logic CLK,
    input  logic nRST,
    input  logic line_i,
    output logic filt_o
);

    localparam int              c_CW  = $clog2(FILTER_LEN + 1);
    localparam logic [c_CW-1:0] c_LEN = c_CW'(FILTER_LEN);

    logic            sync1_q;
    logic            sync2_q;
    logic            last_q;
    logic            filt_q;
    logic [c_CW-1:0] cnt_q;
    logic [c_CW-1:0] cnt_d;

    // Stability run length: restarts at 1 on any change, saturates at FILTER_LEN
    always_comb begin
        cnt_d = cnt_q;
        if (sync2_q != last_q) begin
            cnt_d = c_CW'(1);
        end else if (cnt_q < c_LEN) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Synchroniser, previous-sample register, run counter and filtered level
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            last_q  <= 1'b1;
            filt_q  <= 1'b1;
            cnt_q   <= '0;
        end else begin
            sync1_q <= line_i;
            sync2_q <= sync1_q;
            last_q  <= sync2_q;
            cnt_q   <= cnt_d;
            if (cnt_d == c_LEN) begin
                filt_q <= sync2_q;
            end
        end
    end

    assign filt_o = filt_q;

endmodule

`default_nettype wire

// File: rtl/i2c_bus_frontend.sv
// ============================================================================
// Module      : i2c_bus_frontend
// Description : Multi-bus I2C physical front end. Per bus it filters SDA/SCL,
//               detects START/STOP, tracks busy, flags arbitration loss and
//               SCL-low timeout, registers the open-drain drives and keeps
//               sticky status feeding one maskable interrupt.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module i2c_bus_frontend #(
    parameter int NUM_BUSES      = 1,
    parameter int FILTER_LEN     = 4,
    parameter int TIMEOUT_CYCLES = 65536,
    parameter int TO_W           = 17
) (
    input  logic                   CLK,
    input  logic                   nRST,
    input  logic [NUM_BUSES-1:0]   SDA,
    input  logic [NUM_BUSES-1:0]   SCL,
    input  logic [NUM_BUSES-1:0]   sda_drive,
    input  logic [NUM_BUSES-1:0]   scl_drive,
    output logic [NUM_BUSES-1:0]   SDA_out,
    output logic [NUM_BUSES-1:0]   SCL_out,
    output logic [NUM_BUSES-1:0]   sda_filt,
    output logic [NUM_BUSES-1:0]   scl_filt,
    output logic [NUM_BUSES-1:0]   scl_rise,
    output logic [NUM_BUSES-1:0]   scl_fall,
    output logic [NUM_BUSES-1:0]   bus_busy,
    output logic [4*NUM_BUSES-1:0] status,
    input  logic [4*NUM_BUSES-1:0] status_clr,
    input  logic [4*NUM_BUSES-1:0] irq_en,
    output logic                   interrupt
);

    import i2c_pkg::*;

    // Timeout counter width; kept at least one bit when timeout is disabled
    localparam int c_CW = (TO_W < 1) ? 1 : TO_W;

    logic irq_q;

    genvar b;
    generate
        for (b = 0; b < NUM_BUSES; b++) begin : g_bus

            logic              sda_prev_q;
            logic              scl_prev_q;
            logic              busy_q;
            logic              busy_d;
            logic              sda_out_q;
            logic              scl_out_q;
            logic              rise;
            logic              fall;
            logic              start_ev;
            logic              stop_ev;
            logic              arb_ev;
            logic              to_hit;
            logic [EV_W-1:0]   w_ev;
            i2c_status_t       st_q;
            i2c_status_t       st_d;

            i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_sda_filter (
                .CLK    (CLK),
                .nRST   (nRST),
                .line_i (SDA[b]),
                .filt_o (sda_filt[b])
            );

            i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_scl_filter (
                .CLK    (CLK),
                .nRST   (nRST),
                .line_i (SCL[b]),
                .filt_o (scl_filt[b])
            );

            if (TIMEOUT_CYCLES > 0) begin : g_to
                localparam logic [c_CW-1:0] c_LAST = c_CW'(TIMEOUT_CYCLES - 1);
                logic [c_CW-1:0] to_cnt_q;
                logic [c_CW-1:0] to_cnt_d;

                // Count busy cycles with SCL low; the last one fires and rearms
                always_comb begin
                    to_cnt_d = '0;
                    to_hit   = 1'b0;
                    if (busy_q && !scl_filt[b]) begin
                        if (to_cnt_q >= c_LAST) begin
                            to_hit = 1'b1;
                        end else begin
                            to_cnt_d = to_cnt_q + 1'b1;
                        end
                    end
                end

                // SCL-low run counter
                always_ff @(posedge CLK or negedge nRST) begin
                    if (!nRST) begin
                        to_cnt_q <= '0;
                    end else begin
                        to_cnt_q <= to_cnt_d;
                    end
                end
            end else begin : g_no_to
                assign to_hit = 1'b0;
            end

            // Bus conditions from the current and previous filtered levels
            always_comb begin
                rise     = !scl_prev_q &&  scl_filt[b];
                fall     =  scl_prev_q && !scl_filt[b];
                start_ev =  sda_prev_q && !sda_filt[b] && scl_prev_q && scl_filt[b];
                stop_ev  = !sda_prev_q &&  sda_filt[b] && scl_prev_q && scl_filt[b];
                arb_ev   =  rise && busy_q && sda_drive[b] && !sda_filt[b];
                w_ev           = '0;
                w_ev[EV_START] = start_ev;
                w_ev[EV_STOP]  = stop_ev;
                w_ev[EV_ARB]   = arb_ev;
                w_ev[EV_TO]    = to_hit;
            end

            // Next busy flag and sticky status; a new START and a new event beat clears
            always_comb begin
                busy_d = busy_q;
                if (start_ev) begin
                    busy_d = 1'b1;
                end else if (stop_ev || to_hit) begin
                    busy_d = 1'b0;
                end
                st_d = i2c_status_t'(w_ev | (st_q & ~status_clr[EV_W*b +: EV_W]));
            end

            // Per-bus state; SDA stays released while arbitration loss is pending
            always_ff @(posedge CLK or negedge nRST) begin
                if (!nRST) begin
                    sda_prev_q <= 1'b1;
                    scl_prev_q <= 1'b1;
                    busy_q     <= 1'b0;
                    st_q       <= '0;
                    sda_out_q  <= 1'b1;
                    scl_out_q  <= 1'b1;
                end else begin
                    sda_prev_q <= sda_filt[b];
                    scl_prev_q <= scl_filt[b];
                    busy_q     <= busy_d;
                    st_q       <= st_d;
                    sda_out_q  <= sda_drive[b] | st_d.arb_lost;
                    scl_out_q  <= scl_drive[b];
                end
            end

            assign scl_rise[b]                = rise;
            assign scl_fall[b]                = fall;
            assign bus_busy[b]                = busy_q;
            assign SDA_out[b]                 = sda_out_q;
            assign SCL_out[b]                 = scl_out_q;
            assign status[EV_W*b +: EV_W]     = st_q;
        end
    endgenerate

    // Interrupt follows the registered status by one cycle
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= |(status & irq_en);
        end
    end

    assign interrupt = irq_q;

endmodule

`default_nettype wire
